// File: rtl/credit_arb.sv
`default_nettype none
// ============================================================================
// Module  : credit_arb
// Brief   : Budget-weighted arbiter. One of NUM_M masters owns a decoded bus
//           to NUM_S slaves and pays its request weight on each owned cycle.
// Rev     : 1.0  initial release
// ============================================================================
module credit_arb #(
    parameter int NUM_M    = 4,
    parameter int NUM_S    = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int QW       = 4,
    parameter int BW       = 8,
    parameter int PERIOD   = 8,
    parameter int REFILL   = 20,
    parameter int CAP      = 150,
    parameter int INIT_BUD = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M*QW-1:0]   m_req,
    input  logic [NUM_M*AW-1:0]   m_addr,
    input  logic [NUM_M-1:0]      m_rw,
    input  logic [NUM_M*DW-1:0]   m_wdata,
    output logic [NUM_M-1:0]      m_grant,
    output logic [DW-1:0]         m_rdata,
    output logic [NUM_M-1:0]      m_err,
    output logic [NUM_S-1:0]      s_sel,
    output logic                  s_rw,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic [NUM_S*DW-1:0]   s_rdata
);

    localparam int c_IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int c_SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int c_CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int c_XW = BW + 1;

    localparam logic [c_XW-1:0] c_REFILL = c_XW'(REFILL);
    localparam logic [c_XW-1:0] c_CAP    = c_XW'(CAP);
    localparam logic [BW-1:0]   c_INIT   = BW'(INIT_BUD);
    localparam logic [AW-17:0]  c_HI     = (AW-16)'(16'hFFEF);
    localparam logic [c_IW:0]   c_NUM_M  = (c_IW+1)'(NUM_M);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(PERIOD - 1);

    typedef enum logic [0:0] {
        ST_ARB = 1'b0,
        ST_OWN = 1'b1
    } state_t;

    state_t              r_state;
    logic [NUM_M-1:0]    r_grant;
    logic [c_IW-1:0]     r_owner;
    logic [c_IW-1:0]     r_rr_ptr;
    logic                r_ready;
    logic [c_CW-1:0]     r_cnt;
    logic [BW-1:0]       r_bud [NUM_M];

    logic [QW-1:0]       w_req [NUM_M];
    logic [AW-1:0]       w_addr [NUM_M];
    logic [DW-1:0]       w_wdata [NUM_M];
    logic [DW-1:0]       w_srd [NUM_S];
    logic [NUM_M-1:0]    w_elig;
    logic [c_XW-1:0]     w_chg [NUM_M];
    logic [c_XW-1:0]     w_after_chg [NUM_M];
    logic [c_XW-1:0]     w_after_ref [NUM_M];
    logic [BW-1:0]       w_bud_nxt [NUM_M];

    logic                w_own_elig;
    logic                w_wrap;
    logic                w_win_vld;
    logic [c_IW-1:0]     w_win_idx;
    logic [QW-1:0]       w_win_req;
    logic [c_IW:0]       w_scan;
    logic [c_IW-1:0]     w_rr_next;

    logic [AW-1:0]       w_own_addr;
    logic [3:0]          w_sidx;
    logic                w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_mst
            assign w_req[gi]   = m_req[gi*QW +: QW];
            assign w_addr[gi]  = m_addr[gi*AW +: AW];
            assign w_wdata[gi] = m_wdata[gi*DW +: DW];
            assign w_elig[gi]  = (w_req[gi] != '0) &&
                                 (c_XW'(r_bud[gi]) >= c_XW'(w_req[gi]));

            // Only a tenure that continues this cycle pays; the dropping cycle is free.
            assign w_chg[gi] = (r_state == ST_OWN && r_owner == c_IW'(gi) && w_own_elig)
                               ? c_XW'(w_req[gi]) : '0;
            assign w_after_chg[gi] = (c_XW'(r_bud[gi]) >= w_chg[gi])
                                     ? c_XW'(r_bud[gi]) - w_chg[gi] : '0;
            assign w_after_ref[gi] = w_wrap ? (w_after_chg[gi] + c_REFILL) : w_after_chg[gi];
            assign w_bud_nxt[gi]   = (w_after_ref[gi] > c_CAP) ? BW'(c_CAP)
                                                               : BW'(w_after_ref[gi]);
        end
        for (gi = 0; gi < NUM_S; gi++) begin : g_slv
            assign w_srd[gi] = s_rdata[gi*DW +: DW];
        end
    endgenerate

    assign w_own_elig = w_elig[r_owner];
    assign w_wrap     = (r_cnt == c_LAST);
    assign w_rr_next  = (w_win_idx == c_IW'(NUM_M - 1)) ? '0 : (w_win_idx + 1'b1);

    // Largest weight wins; scanning from rr_ptr with strict '>' keeps the
    // first-seen master on ties, which gives the round-robin order.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_win_req = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_M; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_IW+1)'(k);
            if (w_scan >= c_NUM_M) begin
                w_scan = w_scan - c_NUM_M;
            end
            if (w_elig[w_scan[c_IW-1:0]] &&
                (!w_win_vld || (w_req[w_scan[c_IW-1:0]] > w_win_req))) begin
                w_win_vld = 1'b1;
                w_win_idx = w_scan[c_IW-1:0];
                w_win_req = w_req[w_scan[c_IW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ARB;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            case (r_state)
                ST_ARB: begin
                    // r_ready holds off arbitration on the first edge after reset.
                    if (r_ready && w_win_vld) begin
                        r_state  <= ST_OWN;
                        r_grant  <= NUM_M'(1) << w_win_idx;
                        r_owner  <= w_win_idx;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                ST_OWN: begin
                    if (!w_own_elig) begin
                        r_state <= ST_ARB;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            for (int i = 0; i < NUM_M; i++) begin
                r_bud[i] <= c_INIT;
            end
        end else begin
            r_cnt <= w_wrap ? '0 : (r_cnt + 1'b1);
            for (int i = 0; i < NUM_M; i++) begin
                r_bud[i] <= w_bud_nxt[i];
            end
        end
    end

    assign w_own_addr = w_addr[r_owner];
    assign w_sidx     = w_own_addr[15:12];
    assign w_hit      = (r_state == ST_OWN) &&
                        (w_own_addr[AW-1:16] == c_HI) &&
                        ({1'b0, w_sidx} < 5'(NUM_S));

    always_comb begin
        s_sel   = '0;
        s_rw    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        m_rdata = '0;
        m_err   = '0;
        if (w_hit) begin
            s_sel   = NUM_S'(1) << w_sidx;
            s_rw    = m_rw[r_owner];
            s_addr  = w_own_addr;
            s_wdata = w_wdata[r_owner];
            m_rdata = w_srd[w_sidx[c_SW-1:0]];
        end else if (r_state == ST_OWN) begin
            m_err = r_grant;
        end
    end

    assign m_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_credit_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_credit_arb
// Brief   : Directed bench for credit_arb with a cycle-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_credit_arb;

    localparam int NUM_M = 4, NUM_S = 4, AW = 32, DW = 32, QW = 4, BW = 8;
    localparam int PERIOD = 8, REFILL = 20, CAP = 150, INIT_BUD = 20;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_M*QW-1:0] m_req   = '0;
    logic [NUM_M*AW-1:0] m_addr  = '0;
    logic [NUM_M-1:0]    m_rw    = '0;
    logic [NUM_M*DW-1:0] m_wdata = '0;
    logic [NUM_S*DW-1:0] s_rdata = '0;
    logic [NUM_M-1:0]    m_grant;
    logic [DW-1:0]       m_rdata;
    logic [NUM_M-1:0]    m_err;
    logic [NUM_S-1:0]    s_sel;
    logic                s_rw;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wdata;

    always #5 clk = ~clk;

    credit_arb #(
        .NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW), .QW(QW), .BW(BW),
        .PERIOD(PERIOD), .REFILL(REFILL), .CAP(CAP), .INIT_BUD(INIT_BUD)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
        .m_grant(m_grant), .m_rdata(m_rdata), .m_err(m_err),
        .s_sel(s_sel), .s_rw(s_rw), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), budgets, rr pointer, refill phase.
    int md_bud [NUM_M];
    int md_owner = -1;
    int md_rr    = 0;
    int md_cnt   = 0;
    bit md_ready = 1'b0;
    bit md_valid = 1'b0;

    function automatic int req_of(input int i);
        return int'(m_req[i*QW +: QW]);
    endfunction

    // Inputs change only just after a rising edge, so at the falling edge they
    // are exactly what the next rising edge will sample.
    always @(negedge clk) begin
        logic [AW-1:0] a;
        int            sidx;
        bit            hit;
        bit            el [NUM_M];
        int            nb [NUM_M];
        int            best;
        logic [63:0]   e_grant, e_sel, e_err, e_rdata;

        if (md_valid) begin
            hit = 1'b0;
            a   = '0;
            sidx = 0;
            if (md_owner >= 0) begin
                a    = m_addr[md_owner*AW +: AW];
                sidx = int'(a[15:12]);
                hit  = (a[31:16] == 16'hFFEF) && (sidx < NUM_S);
            end
            e_grant = (md_owner >= 0) ? (64'(1) << md_owner) : 64'(0);
            e_sel   = hit ? (64'(1) << sidx) : 64'(0);
            e_err   = (md_owner >= 0 && !hit) ? (64'(1) << md_owner) : 64'(0);
            e_rdata = hit ? 64'(s_rdata[sidx*DW +: DW]) : 64'(0);
            chk("grant", 64'(m_grant), e_grant);
            chk("s_sel", 64'(s_sel), e_sel);
            chk("m_err", 64'(m_err), e_err);
            chk("m_rdata", 64'(m_rdata), e_rdata);
            if (md_owner < 0 || hit) begin
                chk("s_rw", 64'(s_rw), hit ? 64'(m_rw[md_owner]) : 64'(0));
                chk("s_addr", 64'(s_addr), hit ? 64'(a) : 64'(0));
                chk("s_wdata", 64'(s_wdata), hit ? 64'(m_wdata[md_owner*DW +: DW]) : 64'(0));
            end
            chk("onehot", 64'($onehot0(m_grant) && $onehot0(s_sel)), 64'(1));
            for (int i = 0; i < NUM_M; i++) begin
                chk("budget", 64'(dut.r_bud[i]), 64'(md_bud[i]));
            end
        end

        if (rst) begin
            md_owner = -1;
            md_rr    = 0;
            md_cnt   = 0;
            md_ready = 1'b0;
            for (int i = 0; i < NUM_M; i++) md_bud[i] = INIT_BUD;
            md_valid = 1'b1;
        end else if (md_valid) begin
            for (int i = 0; i < NUM_M; i++) begin
                el[i] = (req_of(i) != 0) && (md_bud[i] >= req_of(i));
                nb[i] = md_bud[i];
            end
            if (md_owner >= 0) begin
                if (el[md_owner]) nb[md_owner] = md_bud[md_owner] - req_of(md_owner);
                else              md_owner = -1;
            end else if (md_ready) begin
                best = -1;
                for (int k = 0; k < NUM_M; k++) begin
                    int j;
                    j = (md_rr + k) % NUM_M;
                    if (el[j] && (best < 0 || req_of(j) > req_of(best))) best = j;
                end
                if (best >= 0) begin
                    md_owner = best;
                    md_rr    = (best + 1) % NUM_M;
                end
            end
            md_ready = 1'b1;
            if (md_cnt == PERIOD - 1) begin
                md_cnt = 0;
                for (int i = 0; i < NUM_M; i++)
                    nb[i] = (nb[i] + REFILL > CAP) ? CAP : nb[i] + REFILL;
            end else begin
                md_cnt++;
            end
            for (int i = 0; i < NUM_M; i++) md_bud[i] = nb[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int v);
        m_req[i*QW +: QW] = QW'(v);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        m_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] req;
        int          hold;
    } vec_t;

    vec_t vecs [8] = '{
        '{16'h0009, 4}, '{16'h000F, 3}, '{16'h5555, 6}, '{16'h1234, 8},
        '{16'h8001, 5}, '{16'hF0F0, 6}, '{16'h0000, 4}, '{16'h2222, 8}
    };

    initial begin
        for (int k = 0; k < NUM_S; k++)
            s_rdata[k*DW +: DW] = 32'hA000_0000 + 32'(k * 32'h111);
        for (int k = 0; k < NUM_M; k++)
            m_addr[k*AW +: AW] = 32'hFFEF_0000 + 32'(k * 32'h1004);

        // Reset values
        do_reset();
        chk("rst_grant", 64'(m_grant), 64'(0));
        chk("rst_sel", 64'(s_sel), 64'(0));
        for (int i = 0; i < NUM_M; i++) chk("rst_bud", 64'(dut.r_bud[i]), 64'(20));

        // Priority: reqs 3,7,5,0
        set_req(0, 3); set_req(1, 7); set_req(2, 5); set_req(3, 0);
        step(); chk("prio_first_edge", 64'(m_grant), 64'(0));
        step(); chk("prio_grant", 64'(m_grant), 64'h2);
                chk("prio_bud0", 64'(dut.r_bud[1]), 64'(20));
        step(); chk("prio_bud1", 64'(dut.r_bud[1]), 64'(13));
        step(); chk("prio_bud2", 64'(dut.r_bud[1]), 64'(6));
                chk("prio_hold", 64'(m_grant), 64'h2);
        step(); chk("prio_drop", 64'(m_grant), 64'(0));
        repeat (4) step();

        // Tie: all weights 4, each owner releases after one owned cycle
        do_reset();
        for (int i = 0; i < NUM_M; i++) set_req(i, 4);
        step();
        for (int g = 0; g < 5; g++) begin
            step(); chk("rr_grant", 64'(m_grant), 64'(1) << (g % 4));
            step(); set_req(g % 4, 0);
            step(); chk("rr_idle", 64'(m_grant), 64'(0));
            set_req(g % 4, 4);
        end

        // Saturation with everyone idle
        do_reset();
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k == 8)  chk("sat_40", 64'(dut.r_bud[0]), 64'(40));
            if (k == 48) chk("sat_140", 64'(dut.r_bud[3]), 64'(140));
            if (k == 56) chk("sat_150", 64'(dut.r_bud[2]), 64'(150));
            if (k == 64) chk("sat_hold", 64'(dut.r_bud[1]), 64'(150));
        end

        // Decode: m2 owns the bus
        do_reset();
        m_addr[2*AW +: AW]  = 32'hFFEF_2220;
        m_rw[2]             = 1'b1;
        m_wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        set_req(2, 1);
        step(); step();
        chk("dec_grant", 64'(m_grant), 64'h4);
        chk("dec_sel", 64'(s_sel), 64'h4);
        chk("dec_addr", 64'(s_addr), 64'hFFEF_2220);
        chk("dec_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
        chk("dec_rw", 64'(s_rw), 64'(1));
        chk("dec_rdata", 64'(m_rdata), 64'hA000_0222);
        m_addr[2*AW +: AW] = 32'hFFEE_0000;
        #1;
        chk("miss_sel", 64'(s_sel), 64'(0));
        chk("miss_err", 64'(m_err), 64'h4);
        chk("miss_rdata", 64'(m_rdata), 64'(0));
        step();
        m_addr[2*AW +: AW] = 32'hFFEF_5000;
        #1;
        chk("range_err", 64'(m_err), 64'h4);
        step();
        m_addr[2*AW +: AW] = 32'hFFEF_3004;
        m_rw[2] = 1'b0;
        #1;
        chk("rd_sel", 64'(s_sel), 64'h8);
        chk("rd_rdata", 64'(m_rdata), 64'hA000_0333);
        step(); step();
        set_req(2, 0);
        step(); step();

        // Charge and refill on the same edge: 10 - 6 + 20
        do_reset();
        repeat (4) step();
        set_req(0, 5);
        step(); step(); step();
        chk("cr_pre", 64'(dut.r_bud[0]), 64'(10));
        set_req(0, 6);
        step();
        chk("cr_post", 64'(dut.r_bud[0]), 64'(24));
        set_req(0, 0);
        step(); step();

        // Reset pulse mid-tenure
        do_reset();
        set_req(1, 2);
        step(); step();
        chk("rm_grant", 64'(m_grant), 64'h2);
        step();
        chk("rm_bud", 64'(dut.r_bud[1]), 64'(18));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_drop", 64'(m_grant), 64'(0));
        for (int i = 0; i < NUM_M; i++) chk("rm_bud_init", 64'(dut.r_bud[i]), 64'(20));
        step(); chk("rm_no_early", 64'(m_grant), 64'(0));
        step(); chk("rm_regrant", 64'(m_grant), 64'h2);

        // Mixed weight patterns, including weight changes mid-tenure
        do_reset();
        foreach (vecs[v]) begin
            m_req = vecs[v].req;
            repeat (vecs[v].hold) step();
        end
        m_req = '0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/credit_arb.md
CREDIT_ARB -- requirements
Module: credit_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_M, 4: master count.
- NUM_S, 4: slave count, power of 2, at most 16.
- AW, 32: address width.
- DW, 32: data width.
- QW, 4: request-weight width.
- BW, 8: budget width.
- PERIOD, 8: refill period in cycles.
- REFILL, 20: budget added per refill.
- CAP, 150: budget ceiling.
- INIT_BUD, 20: budget after reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous active-high reset.
- m_req, in, NUM_M*QW: per-master request weight; 0 means idle.
- m_addr, in, NUM_M*AW: per-master address.
- m_rw, in, NUM_M: per-master read/write, 1 = write.
- m_wdata, in, NUM_M*DW: per-master write data.
- m_grant, out, NUM_M: registered one-hot grant.
- m_rdata, out, DW: read data to the granted master.
- m_err, out, NUM_M: decode error to the granted master.
- s_sel, out, NUM_S: one-hot slave select.
- s_rw, out, 1: read/write to the selected slave.
- s_addr, out, AW: address to the selected slave.
- s_wdata, out, DW: write data to the selected slave.
- s_rdata, in, NUM_S*DW: per-slave read data.
REQ-003 The block SHALL have one clock, clk; reset SHALL be rst, synchronous and active-high; no other clock or async input.

Function
REQ-004 Eligibility: master i is eligible when req_i != 0 and bud_i >= req_i.
REQ-005 The FSM SHALL have two states.
- ARB: when no master is eligible, stay in ARB with grant=0.
- ARB, eligible master present: register a grant to the winner and move to OWN.
- OWN: the grant holds while the owner stays eligible.
- OWN, owner not eligible: drop the grant and return to ARB; new arbitration takes place on the next cycle, giving 1 idle cycle.
REQ-006 The winner SHALL be the eligible master with the largest req.
- Ties are broken round-robin, starting at index rr_ptr.
- rr_ptr becomes (winner+1) mod NUM_M on every grant.
REQ-007 Each cycle in OWN SHALL charge the owner its current req: bud_owner -= req_owner.
REQ-008 Refill counter:
- Counts 0..PERIOD-1 and wraps.
- On the wrap cycle, every budget becomes min(bud + REFILL, CAP).
- This is computed at BW+1 bits; no wrap-around is permitted.
REQ-009 When a charge and a refill fall in the same cycle, the charge SHALL be applied first, then the refill, then saturation at CAP.
REQ-010 Budgets SHALL never underflow; eligibility guarantees this, and a charge greater than bud SHALL clamp to 0 as defensive behaviour.
REQ-011 Address decode SHALL be combinational on the owner's signals.
- Hit: m_addr[AW-1:16] == 16'hFFEF and m_addr[15:12] < NUM_S; the slave index is m_addr[15:12].
- On a hit: assert the indexed s_sel bit; drive s_rw/s_addr/s_wdata from the owner; drive m_rdata from that slave's s_rdata.
- On a miss: s_sel=0, m_err[owner]=1, m_rdata=0; budget is still charged.
REQ-012 When no grant is held, the outputs SHALL be: s_sel=0, s_rw=0, s_addr=0, s_wdata=0, m_rdata=0, m_err=0.
REQ-013 At most one m_grant bit and one s_sel bit SHALL be high in any cycle.
REQ-014 If req_owner changes mid-tenure, the new value SHALL be charged and eligibility re-evaluated with it.

Reset
REQ-015 While rst is high at the clk edge, the following SHALL apply:
- state=ARB, m_grant=0, rr_ptr=0, refill counter=0, all budgets=INIT_BUD.
- All outputs are held at their REQ-012 values.
REQ-016 A reset asserted during OWN SHALL drop the grant on that edge; the first grant can come no earlier than the second edge after rst deasserts.

Verification
REQ-017 Priority, using the default parameters:
- Stimulus: reqs 3,7,5,0 with all budgets 20.
- Response: grant=0010; m1's budget reads 13 after the first OWN cycle, then 6; the grant drops on the third cycle because 6 < 7.
REQ-018 Tie, round-robin:
- Stimulus: reqs 4,4,4,4 held; each master releases after 1 cycle.
- Response: grant order m0, m1, m2, m3, m0, with 1 idle ARB cycle between grants.
REQ-019 Saturation:
- Stimulus: all req=0 for 64 cycles.
- Response: budgets go 20 → 40 → … → 140 → 150, then hold at 150 and never exceed CAP.
REQ-020 Decode:
- Stimulus: owner m2 with addr FFEF_2220 and write=1; then addr FFEE_0000.
- Response: the first access gives s_sel=0100 with s_addr/s_wdata passed through; the second gives s_sel=0000 and m_err=0100.
REQ-021 Charge and refill on the same cycle:
- Stimulus: budget 10, req 6, owner active on the wrap cycle.
- Response: budget becomes 10-6+20=24.
REQ-022 Reset mid-tenure:
- Stimulus: rst pulsed for 1 cycle during OWN.
- Response: m_grant=0 and budgets=20 on that edge; no grant appears on the first edge after rst drops.
